// File: rtl/hazard_forward_pkg.sv
// Shared CPU definitions: register-number width, operand-select codes and
// the hazard unit's shadow-stage records.
package hazard_forward_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] FWD_REG = 2'b00;
    localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
    localparam logic [SEL_W-1:0] FWD_MEM = 2'b10;

    typedef logic [REG_W-1:0] reg_t;

    typedef struct packed {
        reg_t rs;
        reg_t rt;
        reg_t dst;
        logic we;
        logic m2r;
    } stage_e_t;

    typedef struct packed {
        reg_t dst;
        logic we;
        logic m2r;
    } stage_m_t;

    typedef struct packed {
        reg_t dst;
        logic we;
    } stage_w_t;

endpackage

// File: rtl/hazard_stage_reg.sv
// Shadow pipeline-stage register: async reset, hold when disabled,
// load all-zero (bubble) when cleared.
module hazard_stage_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_q <= '0;
        else if (i_en)
            r_q <= i_clr ? '0 : i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_forward.sv
// Hazard unit: tracks E/M/W destination info, raises load-use stalls and
// picks execute-stage operand forwarding sources.
module hazard_forward
    import hazard_forward_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       validD,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic [4:0] wregD,
    input  logic       regwriteD,
    input  logic       memtoregD,
    input  logic       stall_ext,
    output logic [1:0] forwardaE,
    output logic [1:0] forwardbE,
    output logic       stallF,
    output logic       stallD,
    output logic       flushE
);

    stage_e_t w_e_d, w_e_q;
    stage_m_t w_m_d, w_m_q;
    stage_w_t w_w_d, w_w_q;
    logic     w_en;
    logic     w_lwstall;
    logic     w_unused_m2r;

    assign w_en = ~stall_ext;

    assign w_e_d = '{rs: rsD, rt: rtD, dst: wregD,
                     we: regwriteD & validD, m2r: memtoregD & validD};
    assign w_m_d = '{dst: w_e_q.dst, we: w_e_q.we, m2r: w_e_q.m2r};
    assign w_w_d = '{dst: w_m_q.dst, we: w_m_q.we};

    hazard_stage_reg #(.W($bits(stage_e_t))) u_stage_e (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_en),
        .i_clr(w_lwstall),
        .i_d  (w_e_d),
        .o_q  (w_e_q)
    );

    hazard_stage_reg #(.W($bits(stage_m_t))) u_stage_m (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_en),
        .i_clr(1'b0),
        .i_d  (w_m_d),
        .o_q  (w_m_q)
    );

    hazard_stage_reg #(.W($bits(stage_w_t))) u_stage_w (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_en),
        .i_clr(1'b0),
        .i_d  (w_w_d),
        .o_q  (w_w_q)
    );

    // M.m2r is tracked for the datapath's view of the MEM stage; no hazard term reads it.
    assign w_unused_m2r = w_m_q.m2r;

    // A load in E cannot feed a D-stage consumer yet: hold D one cycle.
    assign w_lwstall = validD & w_e_q.we & w_e_q.m2r & (w_e_q.dst != '0) &
                       ((w_e_q.dst == rsD) | (w_e_q.dst == rtD));

    assign stallF = w_lwstall | stall_ext;
    assign stallD = w_lwstall | stall_ext;
    assign flushE = w_lwstall & ~stall_ext;

    function automatic logic [SEL_W-1:0] fwd_sel(input reg_t src,
                                                 input stage_m_t m,
                                                 input stage_w_t w);
        if (src != '0 && m.we && m.dst == src)
            return FWD_MEM;
        else if (src != '0 && w.we && w.dst == src)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    assign forwardaE = fwd_sel(w_e_q.rs, w_m_q, w_w_q);
    assign forwardbE = fwd_sel(w_e_q.rt, w_m_q, w_w_q);

endmodule

// File: tb/tb_hazard_forward.sv
// Scenario bench for hazard_forward: per-cycle expectations are queued as
// each D-stage instruction is driven and checked against {fa, fb, stallF, stallD, flushE}.
module tb_hazard_forward;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] wd;
        logic       rw;
        logic       m2r;
    } ins_t;

    localparam ins_t NOP = '0;

    logic       clk = 1'b0;
    logic       rst;
    logic       validD, regwriteD, memtoregD, stall_ext;
    logic [4:0] rsD, rtD, wregD;
    logic [1:0] forwardaE, forwardbE;
    logic       stallF, stallD, flushE;

    logic [6:0] sb [$];
    logic [6:0] exp_v;
    wire  [6:0] obs = {forwardaE, forwardbE, stallF, stallD, flushE};
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_forward dut (
        .clk      (clk),
        .rst      (rst),
        .validD   (validD),
        .rsD      (rsD),
        .rtD      (rtD),
        .wregD    (wregD),
        .regwriteD(regwriteD),
        .memtoregD(memtoregD),
        .stall_ext(stall_ext),
        .forwardaE(forwardaE),
        .forwardbE(forwardbE),
        .stallF   (stallF),
        .stallD   (stallD),
        .flushE   (flushE)
    );

    function automatic ins_t mk(input int rs, input int rt, input int wd,
                                input int rw, input int m2r);
        ins_t r;
        r.v   = 1'b1;
        r.rs  = 5'(rs);
        r.rt  = 5'(rt);
        r.wd  = 5'(wd);
        r.rw  = 1'(rw);
        r.m2r = 1'(m2r);
        return r;
    endfunction

    task automatic issue(input ins_t i, input logic sx, input logic [6:0] e);
        validD    = i.v;
        rsD       = i.rs;
        rtD       = i.rt;
        wregD     = i.wd;
        regwriteD = i.rw;
        memtoregD = i.m2r;
        stall_ext = sx;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            validD = 1'b0; rsD = '0; rtD = '0; wregD = '0;
            regwriteD = 1'b0; memtoregD = 1'b0; stall_ext = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        issue(mk(5, 5, 5, 1, 1), 1'b1, 7'b0000110);
        #2; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_ext got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
        issue(mk(5, 5, 5, 1, 1), 1'b0, 7'b0000000);
        #2; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL reset_idle got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
        rst = 1'b0;
        idle(3);
    endtask

    task automatic test_mem_fwd();
        ins_t       p [4];
        logic [6:0] e [4];
        p = '{mk(1, 2, 3, 1, 0), mk(3, 4, 6, 1, 0), NOP, NOP};
        e = '{7'b0000000, 7'b0000000, 7'b1000000, 7'b0000000};
        for (int k = 0; k < 4; k++) begin
            issue(p[k], 1'b0, e[k]);
            #2; exp_v = sb.pop_front(); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL mem_fwd[%0d] got=%b exp=%b", k, obs, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_wb_fwd();
        ins_t       p [4];
        logic [6:0] e [4];
        p = '{mk(1, 2, 3, 1, 0), mk(8, 9, 10, 1, 0), mk(11, 3, 12, 1, 0), NOP};
        e = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0001000};
        for (int k = 0; k < 4; k++) begin
            issue(p[k], 1'b0, e[k]);
            #2; exp_v = sb.pop_front(); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL wb_fwd[%0d] got=%b exp=%b", k, obs, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        ins_t       p [4];
        logic [6:0] e [4];
        // D is held by stallD, so the consumer is presented twice.
        p = '{mk(1, 0, 5, 1, 1), mk(5, 6, 7, 1, 0), mk(5, 6, 7, 1, 0), NOP};
        e = '{7'b0000000, 7'b0000111, 7'b0000000, 7'b0100000};
        for (int k = 0; k < 4; k++) begin
            issue(p[k], 1'b0, e[k]);
            #2; exp_v = sb.pop_front(); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL load_use[%0d] got=%b exp=%b", k, obs, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_wb_priority();
        ins_t       p [4];
        logic [6:0] e [4];
        p = '{mk(1, 2, 7, 1, 0), mk(3, 4, 7, 1, 0), mk(7, 8, 9, 1, 0), NOP};
        e = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b1000000};
        for (int k = 0; k < 4; k++) begin
            issue(p[k], 1'b0, e[k]);
            #2; exp_v = sb.pop_front(); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL priority[%0d] got=%b exp=%b", k, obs, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_r0();
        ins_t       p [4];
        logic [6:0] e [4];
        p = '{mk(1, 0, 0, 1, 1), mk(0, 0, 0, 1, 0), mk(0, 0, 4, 1, 0), NOP};
        e = '{7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};
        for (int k = 0; k < 4; k++) begin
            issue(p[k], 1'b0, e[k]);
            #2; exp_v = sb.pop_front(); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL r0[%0d] got=%b exp=%b", k, obs, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_ext_stall();
        ins_t       p  [8];
        logic       sx [8];
        logic [6:0] e  [8];
        // add r3 sits in M during the freeze, so forwardaE=10 shows M held.
        p  = '{mk(1, 2, 3, 1, 0), mk(3, 0, 5, 1, 1), mk(5, 6, 7, 1, 0), mk(5, 6, 7, 1, 0),
               mk(5, 6, 7, 1, 0), mk(5, 6, 7, 1, 0), mk(5, 6, 7, 1, 0), NOP};
        sx = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        e  = '{7'b0000000, 7'b0000000, 7'b1000110, 7'b1000110,
               7'b1000110, 7'b1000111, 7'b0000000, 7'b0100000};
        for (int k = 0; k < 8; k++) begin
            issue(p[k], sx[k], e[k]);
            #2; exp_v = sb.pop_front(); n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL ext_stall[%0d] got=%b exp=%b", k, obs, exp_v); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        issue(mk(1, 2, 3, 1, 0), 1'b0, 7'b0000000);
        #1; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid_c0 got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
        issue(mk(3, 0, 5, 1, 1), 1'b0, 7'b0000000);
        #1; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid_c1 got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
        issue(mk(5, 6, 7, 1, 0), 1'b1, 7'b1000110);
        #1; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid_pre got=%b exp=%b", obs, exp_v); end
        rst = 1'b1;
        sb.push_back(7'b0000110);
        #1; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid_async got=%b exp=%b", obs, exp_v); end
        stall_ext = 1'b0;
        sb.push_back(7'b0000000);
        #1; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid_noext got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
        rst = 1'b0;
        issue(mk(5, 6, 7, 1, 0), 1'b0, 7'b0000000);
        #1; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid_nobubble got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
        issue(mk(7, 0, 8, 1, 0), 1'b0, 7'b0000000);
        #1; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid_next got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
        issue(NOP, 1'b0, 7'b1000000);
        #1; exp_v = sb.pop_front(); n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rst_mid_loaded got=%b exp=%b", obs, exp_v); end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        validD = 1'b0; rsD = '0; rtD = '0; wregD = '0;
        regwriteD = 1'b0; memtoregD = 1'b0; stall_ext = 1'b0;
        @(negedge clk);
        test_reset();
        test_mem_fwd();         idle(3);
        test_wb_fwd();          idle(3);
        test_load_use();        idle(3);
        test_mem_wb_priority(); idle(3);
        test_r0();              idle(3);
        test_ext_stall();       idle(3);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_forward.md
HAZARD_FORWARD -- requirements
Module: hazard_forward

Interface
REQ-001 The block SHALL have no parameters; register-number width is fixed at 5 and select width at 2.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 validD  input  1  decode-stage slot holds a real instruction.
REQ-005 rsD, rtD  input  5 each  decode-stage source register numbers.
REQ-006 wregD  input  5  decode-stage destination register number.
REQ-007 regwriteD  input  1  decode-stage instruction writes the register file.
REQ-008 memtoregD  input  1  decode-stage instruction is a load.
REQ-009 stall_ext  input  1  external freeze (e.g. multi-cycle divider busy).
REQ-010 forwardaE, forwardbE  output  2 each  execute-stage operand-select codes, driven straight into the 3-input operand muxes.
REQ-011 stallF, stallD  output  1 each  hold the PC and the IF/ID register.
REQ-012 flushE  output  1  clear the ID/EX register (insert bubble).

Function
REQ-013 The block SHALL keep internal shadow stages: E{rs,rt,dst,we,m2r}, M{dst,we,m2r}, W{dst,we}.
REQ-014 Select encoding SHALL be 00 = register-file value, 01 = WB-stage result, 10 = MEM-stage ALU result; 11 SHALL never be driven.
REQ-015 lwstall SHALL be validD & E.we & E.m2r & (E.dst != 0) & (E.dst == rsD | E.dst == rtD).
REQ-016 stallF and stallD SHALL both equal lwstall | stall_ext, combinationally in the same cycle.
REQ-017 flushE SHALL equal lwstall & ~stall_ext.
REQ-018 With stall_ext = 0, each rising edge SHALL do W <= M and M <= E.
REQ-019 On the same edge, with stall_ext = 0, E SHALL load a bubble (we = 0, m2r = 0, dst = 0, rs = 0, rt = 0) when lwstall = 1.
REQ-020 Otherwise, with stall_ext = 0, E SHALL load {rsD, rtD, wregD, regwriteD & validD, memtoregD & validD}.
REQ-021 With stall_ext = 1, all shadow stages SHALL hold; stall_ext takes precedence over lwstall.
REQ-022 forwardaE SHALL be 10 if E.rs != 0 & M.we & M.dst == E.rs.
REQ-023 Otherwise forwardaE SHALL be 01 if E.rs != 0 & W.we & W.dst == E.rs, and 00 in all remaining cases.
REQ-024 forwardbE SHALL be derived identically from E.rt.
REQ-025 When MEM and WB both match, the MEM source SHALL win.
REQ-026 forwardaE and forwardbE SHALL depend only on shadow-stage registers, with no combinational path from the D-stage inputs.
REQ-027 A load-use stall SHALL last exactly one cycle, after which the load occupies M and forwarding code 01 covers the consumer one cycle later.
REQ-028 Register 0 SHALL never produce a stall or a forwarding code.

Reset
REQ-029 While rst = 1, all shadow-stage fields SHALL be 0 asynchronously.
REQ-030 While rst = 1, forwardaE = forwardbE = 00 and flushE = 0, and stallF/stallD SHALL reflect stall_ext only.
REQ-031 A reset asserted mid-stall SHALL discard the pending bubble, and the first post-reset edge SHALL load D normally.

Structure
REQ-032 The select codes FWD_REG, FWD_WB and FWD_MEM and the register-number width SHALL live in the shared CPU package and be reused by the datapath mux select logic.
REQ-033 One sub-module SHALL exist: hazard_stage_reg, a resettable shadow-stage register with enable (~stall_ext) and clear (bubble) inputs, instantiated three times.
REQ-034 The match and priority logic SHALL stay in hazard_forward.

Verification
REQ-035 The bench SHALL cover: add r3 issued, then add using rs = 3 next cycle -> forwardaE = 10 in the consumer's E cycle, no stall.
REQ-036 The bench SHALL cover: r3 producer, one unrelated instruction, then consumer rt = 3 -> forwardbE = 01.
REQ-037 The bench SHALL cover: lw r5 followed by an instruction with rs = 5 -> stallF = stallD = flushE = 1 for exactly one cycle, then forwardaE = 01 on the consumer.
REQ-038 The bench SHALL cover: producers of r7 in both M and W, consumer rs = 7 -> forwardaE = 10.
REQ-039 The bench SHALL cover: writes to r0 followed by rs = rt = 0 -> codes 00 and no stall.
REQ-040 The bench SHALL cover: stall_ext held 3 cycles during a load-use -> flushE = 0, stages frozen, a single bubble inserted after release, and rst pulsed mid-sequence -> all outputs 00/0 immediately.
